imem_loader: RTL
================

Name: imem_loader

Overview:
Write-side counterpart to the instruction memory, which the program sequencer only reads.
- Accepts a byte stream over a valid/ready handshake and packs it into 32-bit big-endian words.
- Issues word writes into instruction memory and holds the CPU off until the image is complete.
- Sits between an external boot source (UART/debug bridge) and the instruction memory write port.

Parameters:
DEPTH_WORDS, 256, instruction memory capacity in 32-bit words; images larger than this are rejected.
ADDR_W, 32, width of wr_addr (byte address, matches i_addr).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored in other states.
in_byte  input  8  stream byte.
in_valid  input  1  in_byte valid.
in_ready  output  1  loader accepts in_byte this cycle; transfer occurs when in_valid && in_ready.
wr_en  output  1  instruction memory write strobe, one cycle per word.
wr_addr  output  ADDR_W  byte address of the word being written; word-aligned.
wr_data  output  32  assembled word.
cpu_hold  output  1  high: program sequencer and register writes are frozen.
done  output  1  image loaded successfully; level signal.
error  output  1  header word count exceeded DEPTH_WORDS; level signal.

Behaviour:
- Reset (rst_n=0 at a clk edge), values after that edge:
  - state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, error=0.
  - cpu_hold=1.
  - Reset mid-load abandons the load; words already written stay in memory, the rest is undefined.
- Stream format:
  - 2-byte header N (word count, MSB first).
  - Then N words of 4 bytes each, MSB first: byte0 -> wr_data[31:24] ... byte3 -> wr_data[7:0].
- States:
  - IDLE: in_ready=0, cpu_hold=1. start -> HDR_HI; clears done, error, wr_addr and the byte counter.
  - HDR_HI: in_ready=1. Transfer latches N[15:8] -> HDR_LO.
  - HDR_LO: in_ready=1. Transfer latches N[7:0], then branches on N:
    - N==0 -> DONE.
    - N>DEPTH_WORDS -> ERR.
    - otherwise -> DATA with remaining=N.
  - DATA: in_ready=1. Each transfer shifts one byte into the pack register and increments the 2-bit byte counter. The 4th transfer -> WRITE.
  - WRITE (one cycle):
    - in_ready=0; wr_en=1 with wr_addr/wr_data stable.
    - Next edge: wr_addr += 4, remaining -= 1.
    - Next state: DONE if remaining==1, else DATA.
  - DONE:
    - done=1, cpu_hold=0, in_ready=0.
    - start -> HDR_HI; done drops and cpu_hold rises on the same edge.
  - ERR:
    - error=1, cpu_hold=1, in_ready=0; nothing is written.
    - start -> HDR_HI.
- Throughput and latency:
  - Max throughput is 4 bytes per 5 cycles.
  - wr_en asserts exactly 1 cycle after the edge that accepted byte 3 of a word.
- Handshake rules:
  - in_ready does not depend combinationally on in_valid.
  - in_byte is sampled only on a transfer.
  - Gaps (in_valid=0) stall the loader indefinitely without state change.
- Boundary cases:
  - start while in HDR_*/DATA/WRITE is ignored.
  - N==DEPTH_WORDS is accepted; the last wr_addr is 4*(DEPTH_WORDS-1).
  - wr_addr never wraps for accepted images.
  - The remaining counter is 16 bits wide.

Decomposition:
- Shared package smips_pkg holds:
  - loader_state_t enum (IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR);
  - BYTES_PER_WORD=4;
  - WORD_W=32.
- One natural sub-module, byte_packer: 8-to-32 shift register plus byte counter, with a word_ready output.
- The FSM, address counter and remaining counter stay in imem_loader.
- At the smips top, cpu_hold gates program sequencer advance and register write_enable.

Test Plan:
- Reset then idle 10 cycles -> cpu_hold=1, in_ready=0, wr_en never asserted.
- start; bytes 00 02 DE AD BE EF 00 00 00 01 sent back-to-back -> two writes:
  - wr_addr=0x0 / wr_data=0xDEADBEEF;
  - wr_addr=0x4 / wr_data=0x00000001;
  - then done=1, cpu_hold=0.
- Same image with in_valid low 3 cycles between every byte -> identical writes; no extra or duplicate wr_en.
- Header 01 01 (N=257 > 256) -> error=1 after 2nd byte, zero writes, in_ready=0; start then header 00 00 -> done=1, error=0.
- start, header 00 03, 5 data bytes, then reset -> IDLE outputs per reset list; no further writes; the first word was written to 0x0.
- After DONE, start plus header 00 01 with bytes 12 34 56 78 -> cpu_hold=1 during load, single write at 0x0 of 0x12345678, done=1.

Source files
------------

// File: rtl/smips_pkg.sv
// Shared types and constants for the smips instruction-memory loader.
// Holds the loader state encoding and the big-endian byte packing helper.
package smips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  // The first byte received ends up in the most significant position.
  function automatic logic [WORD_W-1:0] pack_be(input logic [WORD_W-1:0] acc,
                                                input logic [7:0]        b);
    return {acc[WORD_W-9:0], b};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Byte-to-word shift register with a modulo-4 byte counter; word_ready flags the 4th byte.
// Updates one cycle after each accepted byte; it has no flow control and shifts whenever shift_en is high.
module byte_packer
  import smips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        in_byte,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word     <= '0;
      byte_cnt <= '0;
    end else begin
      if (clr) begin
        byte_cnt <= '0;
      end else if (shift_en) begin
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (shift_en) begin
        word <= pack_be(word, in_byte);
      end
    end
  end

  assign word_ready = shift_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory while holding the CPU.
// A write is issued one cycle after a word's 4th byte; in_ready drops for that cycle, giving at most 4 bytes per 5 cycles.
module imem_loader
  import smips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

  loader_state_t     state, state_nxt;
  logic [7:0]        hdr_hi;
  logic [15:0]       remaining;
  logic [16:0]       hdr_n;
  logic              xfer;
  logic              start_ok;
  logic              shift_en;
  logic              word_ready;
  logic [WORD_W-1:0] pack_word;

  assign xfer     = in_valid && in_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign shift_en = xfer && (state == DATA);
  // Zero-extended so the capacity compare cannot overflow.
  assign hdr_n    = {1'b0, hdr_hi, in_byte};

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    cpu_hold  = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = HDR_HI;
      end
      HDR_HI: begin
        in_ready = 1'b1;
        if (xfer) state_nxt = HDR_LO;
      end
      HDR_LO: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (hdr_n == 17'd0)          state_nxt = DONE;
          else if (hdr_n > DEPTH_LIM)  state_nxt = ERR;
          else                         state_nxt = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (word_ready) state_nxt = WRITE;
      end
      WRITE: begin
        wr_en     = 1'b1;
        state_nxt = (remaining == 16'd1) ? DONE : DATA;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nxt = HDR_HI;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_nxt = HDR_HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hdr_hi    <= '0;
      remaining <= '0;
      wr_addr   <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        wr_addr <= '0;
      end else if (state == WRITE) begin
        wr_addr <= wr_addr + ADDR_W'(BYTES_PER_WORD);
      end
      if ((state == HDR_HI) && xfer) begin
        hdr_hi <= in_byte;
      end
      if ((state == HDR_LO) && xfer) begin
        remaining <= hdr_n[15:0];
      end else if (state == WRITE) begin
        remaining <= remaining - 16'd1;
      end
    end
  end

  // The packer holds the word steady through WRITE since no byte is accepted then.
  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .shift_en   (shift_en),
    .in_byte    (in_byte),
    .word       (pack_word),
    .word_ready (word_ready)
  );

  assign wr_data = pack_word;

endmodule
